// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, byte-addressed 8-byte data memory, W pipeline register.
// Optional build macro MEM_BOUNDS_CHECK_EN turns out-of-range accesses into ADR faults instead of wrapping.
module memory_stage #(
  parameter int DEPTH = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_dste,
  input  logic [3:0]  e_dstm,
  input  logic [1:0]  e_status,
  input  logic [63:0] e_vale,
  input  logic [63:0] e_vala,
  input  logic        e_cnd,
  input  logic        M_bubble,
  input  logic        W_stall,
  output logic [3:0]  M_icode,
  output logic [3:0]  M_dste,
  output logic [3:0]  M_dstm,
  output logic [63:0] M_vale,
  output logic [63:0] M_vala,
  output logic        M_cnd,
  output logic [63:0] m_valm,
  output logic [1:0]  m_status,
  output logic [3:0]  W_icode,
  output logic [3:0]  W_dste,
  output logic [3:0]  W_dstm,
  output logic [63:0] W_vale,
  output logic [63:0] W_valm,
  output logic [1:0]  W_status
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_ADR = 2'd2;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [1:0]  status;
    logic [63:0] vale;
    logic [63:0] vala;
    logic        cnd;
  } mreg_t;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [1:0]  status;
    logic [63:0] vale;
    logic [63:0] valm;
  } wreg_t;

  localparam mreg_t M_BUBBLE = '{4'd1, 4'd15, 4'd15, 2'd0, 64'd0, 64'd0, 1'b0};
  localparam wreg_t W_BUBBLE = '{4'd1, 4'd15, 4'd15, 2'd0, 64'd0, 64'd0};

  mreg_t mreg_d;
  mreg_t mreg_q;
  wreg_t wreg_d;
  wreg_t wreg_q;

  logic [7:0]    dmem [DEPTH];
  logic [63:0]   mem_addr_s;
  logic          is_read_s;
  logic          is_write_s;
  logic          oob_s;
  logic          wr_en_s;
  logic [AW-1:0] base_s;
  logic [63:0]   rd_data_s;

  // M register next value: bubble or execute-stage results
  always_comb begin
    mreg_d = M_BUBBLE;
    if (M_bubble) begin
      mreg_d = M_BUBBLE;
    end else begin
      mreg_d = '{e_icode, e_dste, e_dstm, e_status, e_vale, e_vala, e_cnd};
    end
  end

  // M register; reset cancels any write sitting in M
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mreg_q <= M_BUBBLE;
    end else begin
      mreg_q <= mreg_d;
    end
  end

  // Access decode: address source and direction by icode
  always_comb begin
    mem_addr_s = 64'd0;
    is_read_s  = 1'b0;
    is_write_s = 1'b0;
    case (mreg_q.icode)
      4'd4, 4'd8, 4'd10: begin
        mem_addr_s = mreg_q.vale;
        is_write_s = 1'b1;
      end
      4'd5: begin
        mem_addr_s = mreg_q.vale;
        is_read_s  = 1'b1;
      end
      4'd9, 4'd11: begin
        mem_addr_s = mreg_q.vala;
        is_read_s  = 1'b1;
      end
      default: begin
        mem_addr_s = 64'd0;
        is_read_s  = 1'b0;
        is_write_s = 1'b0;
      end
    endcase
  end

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob_s = (is_read_s || is_write_s) && (mem_addr_s > 64'(DEPTH - 8));
`else
  assign oob_s = 1'b0;
`endif

  assign base_s  = mem_addr_s[AW-1:0];
  assign wr_en_s = is_write_s && (mreg_q.status == STAT_AOK) && !oob_s;

  // Little-endian 8-byte read; byte addresses wrap modulo DEPTH
  always_comb begin
    rd_data_s = 64'd0;
    for (int i = 0; i < 8; i++) begin
      rd_data_s[8*i +: 8] = dmem[base_s + AW'(i)];
    end
  end

  // Stage outputs toward W and decode forwarding
  always_comb begin
    m_valm   = 64'd0;
    m_status = mreg_q.status;
    if (is_read_s && !oob_s) begin
      m_valm = rd_data_s;
    end else begin
      m_valm = 64'd0;
    end
    if (oob_s) begin
      m_status = STAT_ADR;
    end else begin
      m_status = mreg_q.status;
    end
  end

  // Data memory write at the edge ending the M cycle; contents survive reset
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      for (int i = 0; i < 8; i++) begin
        dmem[base_s + AW'(i)] <= mreg_q.vala[8*i +: 8];
      end
    end
  end

  // W register next value: hold on stall
  always_comb begin
    wreg_d = wreg_q;
    if (W_stall) begin
      wreg_d = wreg_q;
    end else begin
      wreg_d = '{mreg_q.icode, mreg_q.dste, mreg_q.dstm, m_status, mreg_q.vale, m_valm};
    end
  end

  // W register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wreg_q <= W_BUBBLE;
    end else begin
      wreg_q <= wreg_d;
    end
  end

  assign M_icode  = mreg_q.icode;
  assign M_dste   = mreg_q.dste;
  assign M_dstm   = mreg_q.dstm;
  assign M_vale   = mreg_q.vale;
  assign M_vala   = mreg_q.vala;
  assign M_cnd    = mreg_q.cnd;
  assign W_icode  = wreg_q.icode;
  assign W_dste   = wreg_q.dste;
  assign W_dstm   = wreg_q.dstm;
  assign W_vale   = wreg_q.vale;
  assign W_valm   = wreg_q.valm;
  assign W_status = wreg_q.status;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: vector table plus wrap/bounds and mid-cycle reset sequences.
// Wrap vs. fault expectations follow MEM_BOUNDS_CHECK_EN.
module tb_memory_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  e_icode, e_dste, e_dstm;
  logic [1:0]  e_status;
  logic [63:0] e_vale, e_vala;
  logic        e_cnd;
  logic        M_bubble, W_stall;
  logic [3:0]  M_icode, M_dste, M_dstm;
  logic [63:0] M_vale, M_vala;
  logic        M_cnd;
  logic [63:0] m_valm;
  logic [1:0]  m_status;
  logic [3:0]  W_icode, W_dste, W_dstm;
  logic [63:0] W_vale, W_valm;
  logic [1:0]  W_status;

  int total = 0;
  int bad   = 0;

  memory_stage #(.DEPTH(1024)) dut (
    .clock(clock), .reset(reset),
    .e_icode(e_icode), .e_dste(e_dste), .e_dstm(e_dstm), .e_status(e_status),
    .e_vale(e_vale), .e_vala(e_vala), .e_cnd(e_cnd),
    .M_bubble(M_bubble), .W_stall(W_stall),
    .M_icode(M_icode), .M_dste(M_dste), .M_dstm(M_dstm),
    .M_vale(M_vale), .M_vala(M_vala), .M_cnd(M_cnd),
    .m_valm(m_valm), .m_status(m_status),
    .W_icode(W_icode), .W_dste(W_dste), .W_dstm(W_dstm),
    .W_vale(W_vale), .W_valm(W_valm), .W_status(W_status)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  dste;
    logic [1:0]  st;
    logic [63:0] vale;
    logic [63:0] vala;
    logic        bub;
    logic        stall;
    logic [3:0]  x_micode;
    logic [63:0] x_mvalm;
    logic [1:0]  x_mstat;
    logic [3:0]  x_wicode;
    logic [63:0] x_wvale;
    logic [63:0] x_wvalm;
    logic [1:0]  x_wstat;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] ds, input logic [1:0] st,
                       input logic [63:0] ve, input logic [63:0] va,
                       input logic bub, input logic stl);
    e_icode  = ic;
    e_dste   = ds;
    e_dstm   = 4'd15;
    e_status = st;
    e_vale   = ve;
    e_vala   = va;
    e_cnd    = 1'b1;
    M_bubble = bub;
    W_stall  = stl;
  endtask

  task automatic chk_bubble_state(input string tag);
    chk({tag, "_M_icode"}, 64'(M_icode), 64'd1);
    chk({tag, "_M_dste"},  64'(M_dste),  64'd15);
    chk({tag, "_M_dstm"},  64'(M_dstm),  64'd15);
    chk({tag, "_M_vale"},  M_vale,       64'd0);
    chk({tag, "_M_vala"},  M_vala,       64'd0);
    chk({tag, "_M_cnd"},   64'(M_cnd),   64'd0);
    chk({tag, "_W_icode"}, 64'(W_icode), 64'd1);
    chk({tag, "_W_dste"},  64'(W_dste),  64'd15);
    chk({tag, "_W_dstm"},  64'(W_dstm),  64'd15);
    chk({tag, "_W_vale"},  W_vale,       64'd0);
    chk({tag, "_W_valm"},  W_valm,       64'd0);
    chk({tag, "_W_status"}, 64'(W_status), 64'd0);
  endtask

  initial begin
    //          icode  dste   st    vale       vala                     bub   stl   Micode m_valm                  mst   Wicode W_vale    W_valm                  Wst
    vecs[0]  = '{4'd4,  4'd15, 2'd0, 64'h10,    64'h1122334455667788,    1'b0, 1'b0, 4'd4,  64'h0,                  2'd0, 4'd1,  64'h0,    64'h0,                  2'd0};
    vecs[1]  = '{4'd5,  4'd15, 2'd0, 64'h10,    64'h0,                   1'b0, 1'b0, 4'd5,  64'h1122334455667788,   2'd0, 4'd4,  64'h10,   64'h0,                  2'd0};
    vecs[2]  = '{4'd10, 4'd4,  2'd0, 64'h1F8,   64'hAB,                  1'b0, 1'b0, 4'd10, 64'h0,                  2'd0, 4'd5,  64'h10,   64'h1122334455667788,   2'd0};
    vecs[3]  = '{4'd11, 4'd4,  2'd0, 64'h200,   64'h1F8,                 1'b0, 1'b0, 4'd11, 64'hAB,                 2'd0, 4'd10, 64'h1F8,  64'h0,                  2'd0};
    vecs[4]  = '{4'd4,  4'd15, 2'd0, 64'h20,    64'hCAFE,                1'b0, 1'b0, 4'd4,  64'h0,                  2'd0, 4'd11, 64'h200,  64'hAB,                 2'd0};
    vecs[5]  = '{4'd4,  4'd15, 2'd0, 64'h20,    64'hDEAD,                1'b1, 1'b0, 4'd1,  64'h0,                  2'd0, 4'd4,  64'h20,   64'h0,                  2'd0};
    vecs[6]  = '{4'd5,  4'd15, 2'd0, 64'h20,    64'h0,                   1'b0, 1'b0, 4'd5,  64'hCAFE,               2'd0, 4'd1,  64'h0,    64'h0,                  2'd0};
    vecs[7]  = '{4'd8,  4'd4,  2'd0, 64'h100,   64'h1234,                1'b0, 1'b0, 4'd8,  64'h0,                  2'd0, 4'd5,  64'h20,   64'hCAFE,               2'd0};
    vecs[8]  = '{4'd9,  4'd4,  2'd0, 64'h108,   64'h100,                 1'b0, 1'b1, 4'd9,  64'h1234,               2'd0, 4'd5,  64'h20,   64'hCAFE,               2'd0};
    vecs[9]  = '{4'd2,  4'd6,  2'd0, 64'h7,     64'h0,                   1'b0, 1'b1, 4'd2,  64'h0,                  2'd0, 4'd5,  64'h20,   64'hCAFE,               2'd0};
    vecs[10] = '{4'd1,  4'd15, 2'd0, 64'h0,     64'h0,                   1'b0, 1'b0, 4'd1,  64'h0,                  2'd0, 4'd2,  64'h7,    64'h0,                  2'd0};
    vecs[11] = '{4'd4,  4'd15, 2'd1, 64'h10,    64'hFF,                  1'b0, 1'b0, 4'd4,  64'h0,                  2'd1, 4'd1,  64'h0,    64'h0,                  2'd0};
    vecs[12] = '{4'd5,  4'd15, 2'd0, 64'h10,    64'h0,                   1'b0, 1'b0, 4'd5,  64'h1122334455667788,   2'd0, 4'd4,  64'h10,   64'h0,                  2'd1};
    vecs[13] = '{4'd1,  4'd15, 2'd3, 64'h0,     64'h0,                   1'b0, 1'b0, 4'd1,  64'h0,                  2'd3, 4'd5,  64'h10,   64'h1122334455667788,   2'd0};
    vecs[14] = '{4'd1,  4'd15, 2'd0, 64'h0,     64'h0,                   1'b1, 1'b1, 4'd1,  64'h0,                  2'd0, 4'd5,  64'h10,   64'h1122334455667788,   2'd0};

    drive(4'd1, 4'd15, 2'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk_bubble_state("rst_async");
    step();
    step();
    reset = 1'b0;
    chk_bubble_state("rst_held");

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].icode, vecs[i].dste, vecs[i].st, vecs[i].vale, vecs[i].vala,
            vecs[i].bub, vecs[i].stall);
      step();
      chk($sformatf("v%0d_M_icode", i), 64'(M_icode), 64'(vecs[i].x_micode));
      chk($sformatf("v%0d_M_dste", i), 64'(M_dste), vecs[i].bub ? 64'd15 : 64'(vecs[i].dste));
      chk($sformatf("v%0d_M_vale", i), M_vale, vecs[i].bub ? 64'd0 : vecs[i].vale);
      chk($sformatf("v%0d_M_cnd", i), 64'(M_cnd), vecs[i].bub ? 64'd0 : 64'd1);
      chk($sformatf("v%0d_m_valm", i), m_valm, vecs[i].x_mvalm);
      chk($sformatf("v%0d_m_status", i), 64'(m_status), 64'(vecs[i].x_mstat));
      chk($sformatf("v%0d_W_icode", i), 64'(W_icode), 64'(vecs[i].x_wicode));
      chk($sformatf("v%0d_W_vale", i), W_vale, vecs[i].x_wvale);
      chk($sformatf("v%0d_W_valm", i), W_valm, vecs[i].x_wvalm);
      chk($sformatf("v%0d_W_status", i), 64'(W_status), 64'(vecs[i].x_wstat));
    end

    // Top-of-memory write at DEPTH-4: wraps by default, faults with the bounds check
    drive(4'd4, 4'd15, 2'd0, 64'h0, 64'h0, 1'b0, 1'b0);
    step();
    drive(4'd4, 4'd15, 2'd0, 64'h3FC, 64'h0807060504030201, 1'b0, 1'b0);
    step();
`ifdef MEM_BOUNDS_CHECK_EN
    chk("wrap_wr_m_status", 64'(m_status), 64'd2);
`else
    chk("wrap_wr_m_status", 64'(m_status), 64'd0);
`endif
    chk("wrap_wr_m_valm", m_valm, 64'd0);
    drive(4'd5, 4'd15, 2'd0, 64'h3FC, 64'h0, 1'b0, 1'b0);
    step();
`ifdef MEM_BOUNDS_CHECK_EN
    chk("wrap_W_status", 64'(W_status), 64'd2);
    chk("wrap_rd_hi_status", 64'(m_status), 64'd2);
    chk("wrap_rd_hi_valm", m_valm, 64'd0);
`else
    chk("wrap_W_status", 64'(W_status), 64'd0);
    chk("wrap_rd_hi_status", 64'(m_status), 64'd0);
    chk("wrap_rd_hi_valm", m_valm, 64'h0807060504030201);
`endif
    drive(4'd5, 4'd15, 2'd0, 64'h0, 64'h0, 1'b0, 1'b0);
    step();
    chk("wrap_rd_lo_status", 64'(m_status), 64'd0);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("wrap_rd_lo_valm", m_valm, 64'h0);
`else
    chk("wrap_rd_lo_valm", m_valm, 64'h0000000008070605);
`endif

    // Reset mid-cycle with a write in M: bubble at once, write cancelled, memory kept
    drive(4'd4, 4'd15, 2'd0, 64'h10, 64'h9999, 1'b0, 1'b0);
    step();
    chk("rstw_M_icode_pre", 64'(M_icode), 64'd4);
    #3 reset = 1'b1;
    #1;
    chk_bubble_state("rst_mid");
    chk("rst_mid_m_valm", m_valm, 64'd0);
    drive(4'd5, 4'd15, 2'd0, 64'h10, 64'h0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    step();
    chk("rst_keep_M_icode", 64'(M_icode), 64'd5);
    chk("rst_keep_m_valm", m_valm, 64'h1122334455667788);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
